// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and state encoding for the shift-add multiplier control.
// Contents: counter width, counter load value, 3-bit state codes and the state enum.
// Used by mult_control_if and mult_control.
package mult_pkg;

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    TEST  = S_TEST,
    ADD   = S_ADD,
    SHIFT = S_SHIFT,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/mult_control_if.sv
// mult_control_if: bundles the start/done handshake, datapath status and control strobes.
// Ports: start, q0, cnt flow into the controller; ldcnt, decr, clrA, ldA, ldB, ldQ,
// shift, busy, done flow out. master = system/datapath side, slave = controller side.
interface mult_control_if;
  import mult_pkg::*;

  logic             start;
  logic             q0;
  logic [CNT_W-1:0] cnt;
  logic             ldcnt;
  logic             decr;
  logic             clrA;
  logic             ldA;
  logic             ldB;
  logic             ldQ;
  logic             shift;
  logic             busy;
  logic             done;

  modport master (
    output start, q0, cnt,
    input  ldcnt, decr, clrA, ldA, ldB, ldQ, shift, busy, done
  );

  modport slave (
    input  start, q0, cnt,
    output ldcnt, decr, clrA, ldA, ldB, ldQ, shift, busy, done
  );

endinterface

// File: rtl/mult_control.sv
// mult_control: Moore control FSM for the shift-add multiplier (iteration counter loaded to 9).
// Latency: done rises 20 + (number of ADD visits) edges after start is sampled in IDLE.
// Ports: clk, rst (async, active-high), bus (slave modport); start is ignored while busy.
module mult_control
  import mult_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mult_control_if.slave bus
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counter exhaustion wins over q0 so the loop ends cleanly after the last shift.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.start ? LOAD : IDLE;
      LOAD:    state_nxt = TEST;
      TEST: begin
        if (bus.cnt == '0)  state_nxt = DONE;
        else if (bus.q0)    state_nxt = ADD;
        else                state_nxt = SHIFT;
      end
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = TEST;
      // Holding start keeps the result visible; a new job needs start to drop first.
      DONE:    state_nxt = bus.start ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from the state register only.
  always_comb begin
    bus.ldcnt = 1'b0;
    bus.decr  = 1'b0;
    bus.clrA  = 1'b0;
    bus.ldA   = 1'b0;
    bus.ldB   = 1'b0;
    bus.ldQ   = 1'b0;
    bus.shift = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      LOAD: begin
        bus.ldcnt = 1'b1;
        bus.ldB   = 1'b1;
        bus.ldQ   = 1'b1;
        bus.clrA  = 1'b1;
        bus.busy  = 1'b1;
      end
      TEST: bus.busy = 1'b1;
      ADD: begin
        bus.ldA  = 1'b1;
        bus.busy = 1'b1;
      end
      SHIFT: begin
        bus.shift = 1'b1;
        bus.decr  = 1'b1;
        bus.busy  = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: bench for mult_control with counter and multiplier-register models.
// Ports: none; instantiates mult_control_if and drives the master side.
// Expected strobe counts and latency come from the popcount of the 9 bits seen at TEST.
module tb_mult_control;
  import mult_pkg::*;

  logic clk;
  logic rst;
  mult_control_if bus ();

  mult_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Datapath models: iteration counter and a 9-bit view of Q as the controller sees it.
  logic [CNT_W-1:0] cnt_m = '0;
  logic [8:0]       q_m   = '0;
  logic [8:0]       q_load = '0;
  logic             force_zero = 1'b0;

  always @(posedge clk) begin
    if (bus.ldcnt)     cnt_m <= CNT_INIT;
    else if (bus.decr) cnt_m <= cnt_m - 1'b1;
    if (bus.ldQ)        q_m <= q_load;
    else if (bus.shift) q_m <= q_m >> 1;
  end

  assign bus.cnt = force_zero ? '0 : cnt_m;
  assign bus.q0  = q_m[0];

  function automatic logic [8:0] outs();
    return {bus.ldcnt, bus.decr, bus.clrA, bus.ldA, bus.ldB, bus.ldQ,
            bus.shift, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation; returns latency in edges after the start edge and strobe counts.
  task automatic run_op(input logic [8:0] qval, input bit hold,
                        output int lat, output int n_lda, output int n_decr,
                        output int n_shift, output int n_ldcnt, output int viol);
    int  k;
    bit  prev_lda;
    int  grp;
    lat = -1; n_lda = 0; n_decr = 0; n_shift = 0; n_ldcnt = 0; viol = 0;
    prev_lda = 1'b0;
    q_load = qval;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        if (bus.busy) viol++;
        break;
      end
      n_lda   += int'(bus.ldA);
      n_decr  += int'(bus.decr);
      n_shift += int'(bus.shift);
      n_ldcnt += int'(bus.ldcnt);
      grp = int'(bus.ldcnt | bus.ldB | bus.ldQ | bus.clrA) + int'(bus.ldA) + int'(bus.shift);
      if (grp > 1) viol++;
      if (!(bus.ldcnt == bus.ldB && bus.ldB == bus.ldQ && bus.ldQ == bus.clrA)) viol++;
      if (bus.shift != bus.decr) viol++;
      if (!bus.busy) viol++;
      if (prev_lda && !bus.shift) viol++;
      prev_lda = bus.ldA;
      @(posedge clk);
      k++;
    end
    if (lat < 0) $display("FAIL timeout: done not seen within %0d edges", k);
  endtask

  typedef struct {
    logic [8:0] qval;
    int         exp_lda;
    int         exp_lat;
  } vec_t;

  task automatic op_and_check(input string tag, input logic [8:0] qval, input bit hold,
                              input int exp_lda, input int exp_lat);
    int lat, n_lda, n_decr, n_shift, n_ldcnt, viol;
    run_op(qval, hold, lat, n_lda, n_decr, n_shift, n_ldcnt, viol);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ldA count"}, n_lda, exp_lda);
    check({tag, " decr count"}, n_decr, 9);
    check({tag, " shift count"}, n_shift, 9);
    check({tag, " load count"}, n_ldcnt, 1);
    check({tag, " strobe rules"}, viol, 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [8:0] rq;
    int lat, n_lda, n_decr, n_shift, n_ldcnt, viol;
    int found;

    vecs[0] = '{9'h000, 0, 20};
    vecs[1] = '{9'h1FF, 9, 29};
    vecs[2] = '{9'h0A5, 4, 24};
    vecs[3] = '{9'h1A5, 5, 25};
    vecs[4] = '{9'h155, 5, 25};
    vecs[5] = '{9'h100, 1, 21};

    rst = 1'b1;
    bus.start = 1'b0;
    #3;
    check("reset outputs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle outputs", int'(outs()), 0);

    // Table of directed operands.
    for (int i = 0; i < 6; i++)
      op_and_check($sformatf("vec%0d", i), vecs[i].qval, 1'b0, vecs[i].exp_lda, vecs[i].exp_lat);

    // Random operands against the popcount model.
    for (int i = 0; i < 6; i++) begin
      rq = 9'($urandom_range(0, 511));
      op_and_check($sformatf("rand%0d q=%03h", i, rq), rq, 1'b0,
                   $countones(rq), 20 + $countones(rq));
    end

    // Start held high through DONE: done sticks, no second load.
    op_and_check("hold", 9'h0A5, 1'b1, 4, 24);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold done %0d", i), int'(outs()), 1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("idle after release", int'(outs()), 0);
    op_and_check("restart", 9'h033, 1'b0, 4, 24);

    // Counter reads zero at the first TEST: straight to DONE.
    force_zero = 1'b1;
    run_op(9'h1FF, 1'b0, lat, n_lda, n_decr, n_shift, n_ldcnt, viol);
    force_zero = 1'b0;
    check("cnt0 latency", lat, 2);
    check("cnt0 ldA", n_lda, 0);
    check("cnt0 shift", n_shift, 0);
    check("cnt0 decr", n_decr, 0);
    check("cnt0 load", n_ldcnt, 1);

    // Asynchronous reset while in ADD.
    @(negedge clk);
    q_load = 9'h1FF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ldA) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("reach ADD", found, 1);
    #1 rst = 1'b1;
    #1 check("reset mid-ADD outputs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle %0d", i), int'(outs()), 0);
    end
    op_and_check("after reset", 9'h081, 1'b0, 2, 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
